cstuff_consumer: RTL and testbench

CSTUFF_CONSUMER -- requirements
Module: cstuff_consumer

---
 rtl/cstuff_consumer.sv | 183 ++++++++++++++++++
 tb/tb_cstuff_consumer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cstuff_consumer.sv
// cstuff_consumer: buffers cStuff beats in a small FIFO, drains them once a
// start notification has been seen, and serves occupancy-threshold / flush
// commands over a req/ack handshake.
//
// Ports:
//   clk              sole clock, rising edge
//   rst_n            synchronous reset, active HIGH despite the name
//   cStuffIf_vld     upstream beat valid
//   cStuffIf_data    upstream beat payload (5 bits)
//   cStuffIf_rdy     block accepts beat (!full, 0 during reset/flush)
//   aStuffIf_req     command request, held until ack
//   aStuffIf_data    command: [3] flush, [2:0] occupancy threshold
//   aStuffIf_ack     one-cycle command completion pulse
//   aStuffIf_rdata   response: captured count >= threshold (valid with ack)
//   startDone_notify start notification
//   startDone_ack    one-cycle acknowledge, cycle after notify rises
//   out_vld          drain-side beat valid (started & !empty)
//   out_data         FIFO head, 0 when out_vld is low
//   out_rdy          drain-side consumer ready
//   count            current FIFO occupancy
module cstuff_consumer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ACK_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cStuffIf_vld,
    input  logic [4:0]                 cStuffIf_data,
    output logic                       cStuffIf_rdy,
    input  logic                       aStuffIf_req,
    input  logic [3:0]                 aStuffIf_data,
    output logic                       aStuffIf_ack,
    output logic                       aStuffIf_rdata,
    input  logic                       startDone_notify,
    output logic                       startDone_ack,
    output logic                       out_vld,
    output logic [4:0]                 out_data,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_WAIT,
        CMD_ACK,
        CMD_HOLD
    } cmdState_t;

    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] countQ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          flushNow;

    logic          started;
    logic          notifyQ;
    logic          sdAck;

    cmdState_t     state;
    cmdState_t     stateNext;
    logic [3:0]    dly;
    logic [3:0]    dlyNext;
    logic [3:0]    capData;
    logic [CW-1:0] capCount;

    assign full     = (countQ == CW'(DEPTH));
    assign empty    = (countQ == '0);
    assign flushNow = (state == CMD_ACK) && capData[3];

    // rdy is gated by the reset input so it reads 0 while reset is held and
    // returns to 1 in the very first cycle after release.
    assign cStuffIf_rdy = !rst_n && !full && !flushNow;
    assign out_vld      = started && !empty && !flushNow;
    assign out_data     = out_vld ? mem[rdPtr] : '0;
    assign count        = countQ;

    assign push = cStuffIf_vld && cStuffIf_rdy;
    assign pop  = out_vld && out_rdy;

    // Storage is not reset; push is already 0 during reset and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= cStuffIf_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            countQ <= '0;
        end else if (flushNow) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            countQ <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   countQ <= countQ + CW'(1);
                2'b01:   countQ <= countQ - CW'(1);
                default: countQ <= countQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            started <= 1'b0;
            notifyQ <= 1'b0;
            sdAck   <= 1'b0;
        end else begin
            notifyQ <= startDone_notify;
            sdAck   <= startDone_notify && !notifyQ;
            if (startDone_notify) begin
                started <= 1'b1;
            end
        end
    end

    assign startDone_ack = sdAck;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= CMD_IDLE;
            dly      <= '0;
            capData  <= '0;
            capCount <= '0;
        end else begin
            state <= stateNext;
            dly   <= dlyNext;
            if (state == CMD_IDLE && aStuffIf_req) begin
                capData  <= aStuffIf_data;
                capCount <= countQ;
            end
        end
    end

    always_comb begin
        stateNext = state;
        dlyNext   = dly;
        case (state)
            CMD_IDLE: begin
                if (aStuffIf_req) begin
                    stateNext = CMD_WAIT;
                    dlyNext   = 4'(ACK_DELAY - 1);
                end
            end
            CMD_WAIT: begin
                if (dly == '0) begin
                    stateNext = CMD_ACK;
                end else begin
                    dlyNext = dly - 4'd1;
                end
            end
            CMD_ACK: begin
                stateNext = CMD_HOLD;
            end
            CMD_HOLD: begin
                if (!aStuffIf_req) begin
                    stateNext = CMD_IDLE;
                end
            end
            default: stateNext = CMD_IDLE;
        endcase
    end

    assign aStuffIf_ack   = (state == CMD_ACK);
    assign aStuffIf_rdata = (state == CMD_ACK) &&
                            (5'(capCount) >= 5'(capData[2:0]));

endmodule

// File: tb/tb_cstuff_consumer.sv
// Directed bench for cstuff_consumer (DEPTH=4, ACK_DELAY=2). Inputs change
// 1ns after the rising edge; outputs are checked at that same point.
module tb_cstuff_consumer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cStuffIf_vld;
    logic [4:0] cStuffIf_data;
    logic       cStuffIf_rdy;
    logic       aStuffIf_req;
    logic [3:0] aStuffIf_data;
    logic       aStuffIf_ack;
    logic       aStuffIf_rdata;
    logic       startDone_notify;
    logic       startDone_ack;
    logic       out_vld;
    logic [4:0] out_data;
    logic       out_rdy;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cstuff_consumer #(.DEPTH(4), .ACK_DELAY(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cStuffIf_vld     (cStuffIf_vld),
        .cStuffIf_data    (cStuffIf_data),
        .cStuffIf_rdy     (cStuffIf_rdy),
        .aStuffIf_req     (aStuffIf_req),
        .aStuffIf_data    (aStuffIf_data),
        .aStuffIf_ack     (aStuffIf_ack),
        .aStuffIf_rdata   (aStuffIf_rdata),
        .startDone_notify (startDone_notify),
        .startDone_ack    (startDone_ack),
        .out_vld          (out_vld),
        .out_data         (out_data),
        .out_rdy          (out_rdy),
        .count            (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; cStuffIf_vld = 1'b0; cStuffIf_data = '0;
        aStuffIf_req = 1'b0; aStuffIf_data = '0; startDone_notify = 1'b0;
        out_rdy = 1'b0;
        step();
        total++; if (cStuffIf_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%0d exp=0", cStuffIf_rdy); end
        total++; if (aStuffIf_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0d exp=0", aStuffIf_ack); end
        total++; if (aStuffIf_rdata !== 1'b0) begin bad++; $display("FAIL reset_rdata got=%0d exp=0", aStuffIf_rdata); end
        total++; if (startDone_ack !== 1'b0) begin bad++; $display("FAIL reset_sdack got=%0d exp=0", startDone_ack); end
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_outvld got=%0d exp=0", out_vld); end
        total++; if (out_data !== 5'h00) begin bad++; $display("FAIL reset_outdata got=%0h exp=0", out_data); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        rst_n = 1'b0;
        #1;
        total++; if (cStuffIf_rdy !== 1'b1) begin bad++; $display("FAIL reset_release_rdy got=%0d exp=1", cStuffIf_rdy); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            cStuffIf_vld  = 1'b1;
            cStuffIf_data = 5'(i);
            total++; if (cStuffIf_rdy !== (i <= 4)) begin bad++; $display("FAIL fill_rdy beat=%0d got=%0d exp=%0d", i, cStuffIf_rdy, (i <= 4)); end
            step();
        end
        cStuffIf_vld = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
        total++; if (cStuffIf_rdy !== 1'b0) begin bad++; $display("FAIL fill_full_rdy got=%0d exp=0", cStuffIf_rdy); end
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL fill_outvld got=%0d exp=0", out_vld); end
    endtask

    task automatic test_start_drain();
        startDone_notify = 1'b1;
        step();
        total++; if (startDone_ack !== 1'b1) begin bad++; $display("FAIL start_ack got=%0d exp=1", startDone_ack); end
        total++; if (out_vld !== 1'b1) begin bad++; $display("FAIL start_outvld got=%0d exp=1", out_vld); end
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (startDone_ack !== 1'b0) begin bad++; $display("FAIL start_ack_single cyc=%0d got=%0d exp=0", k, startDone_ack); end
            total++; if (out_data !== 5'h01) begin bad++; $display("FAIL start_hold_data cyc=%0d got=%0h exp=1", k, out_data); end
        end
        startDone_notify = 1'b0;
        out_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            total++; if (out_vld !== 1'b1) begin bad++; $display("FAIL drain_vld beat=%0d got=%0d exp=1", k, out_vld); end
            total++; if (out_data !== 5'(k)) begin bad++; $display("FAIL drain_data beat=%0d got=%0h exp=%0h", k, out_data, k); end
            step();
        end
        out_rdy = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL drain_empty_vld got=%0d exp=0", out_vld); end
    endtask

    task automatic test_command();
        logic [3:0] cmdData [2] = '{4'h3, 4'h5};
        logic       expData [2] = '{1'b1, 1'b0};
        int         holdCyc [2] = '{0, 3};
        for (int i = 0; i < 3; i++) begin
            cStuffIf_vld = 1'b1; cStuffIf_data = 5'(5'h0A + i);
            step();
        end
        cStuffIf_vld = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL cmd_setup_count got=%0d exp=3", count); end
        for (int c = 0; c < 2; c++) begin
            aStuffIf_req = 1'b1; aStuffIf_data = cmdData[c];
            for (int j = 1; j <= 3; j++) begin
                step();
                if (j < 3) begin
                    total++; if (aStuffIf_ack !== 1'b0) begin bad++; $display("FAIL cmd_early_ack cmd=%0d cyc=%0d got=%0d exp=0", c, j, aStuffIf_ack); end
                end else begin
                    total++; if (aStuffIf_ack !== 1'b1) begin bad++; $display("FAIL cmd_ack cmd=%0d got=%0d exp=1", c, aStuffIf_ack); end
                    total++; if (aStuffIf_rdata !== expData[c]) begin bad++; $display("FAIL cmd_rdata cmd=%0d got=%0d exp=%0d", c, aStuffIf_rdata, expData[c]); end
                end
            end
            for (int h = 0; h < holdCyc[c]; h++) begin
                step();
                total++; if (aStuffIf_ack !== 1'b0) begin bad++; $display("FAIL cmd_hold_ack cmd=%0d cyc=%0d got=%0d exp=0", c, h, aStuffIf_ack); end
            end
            aStuffIf_req = 1'b0;
            for (int h = 0; h < 2; h++) begin
                step();
                total++; if (aStuffIf_ack !== 1'b0) begin bad++; $display("FAIL cmd_release_ack cmd=%0d cyc=%0d got=%0d exp=0", c, h, aStuffIf_ack); end
            end
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL cmd_count_kept got=%0d exp=3", count); end
    endtask

    task automatic test_flush();
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL flush_setup_count got=%0d exp=2", count); end
        aStuffIf_req = 1'b1; aStuffIf_data = 4'h8;
        cStuffIf_vld = 1'b1; cStuffIf_data = 5'h1F;
        step();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_wait1_count got=%0d exp=3", count); end
        step();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL flush_wait2_count got=%0d exp=4", count); end
        step();
        total++; if (aStuffIf_ack !== 1'b1) begin bad++; $display("FAIL flush_ack got=%0d exp=1", aStuffIf_ack); end
        total++; if (aStuffIf_rdata !== 1'b1) begin bad++; $display("FAIL flush_rdata got=%0d exp=1", aStuffIf_rdata); end
        total++; if (cStuffIf_rdy !== 1'b0) begin bad++; $display("FAIL flush_rdy got=%0d exp=0", cStuffIf_rdy); end
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL flush_outvld got=%0d exp=0", out_vld); end
        aStuffIf_req = 1'b0;
        step();
        cStuffIf_vld = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (cStuffIf_rdy !== 1'b1) begin bad++; $display("FAIL flush_after_rdy got=%0d exp=1", cStuffIf_rdy); end
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL flush_after_outvld got=%0d exp=0", out_vld); end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0] q [$];
        for (int i = 0; i < 2; i++) begin
            cStuffIf_vld = 1'b1; cStuffIf_data = 5'(5'h14 + i);
            q.push_back(5'(5'h14 + i));
            step();
        end
        for (int i = 0; i < 10; i++) begin
            cStuffIf_vld = 1'b1; cStuffIf_data = 5'(5'h16 + i);
            out_rdy = 1'b1;
            total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count cyc=%0d got=%0d exp=2", i, count); end
            total++; if (out_data !== q[0]) begin bad++; $display("FAIL b2b_order cyc=%0d got=%0h exp=%0h", i, out_data, q[0]); end
            step();
            void'(q.pop_front());
            q.push_back(5'(5'h16 + i));
        end
        cStuffIf_vld = 1'b0; out_rdy = 1'b0;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_final_count got=%0d exp=2", count); end
        total++; if (out_data !== q[0]) begin bad++; $display("FAIL b2b_final_head got=%0h exp=%0h", out_data, q[0]); end
    endtask

    task automatic test_reset_mid();
        cStuffIf_vld = 1'b1; cStuffIf_data = 5'h07;
        step();
        cStuffIf_vld = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL rmid_setup_count got=%0d exp=3", count); end
        aStuffIf_req = 1'b1; aStuffIf_data = 4'h2;
        step();
        rst_n = 1'b1; aStuffIf_req = 1'b0;
        #1;
        total++; if (cStuffIf_rdy !== 1'b0) begin bad++; $display("FAIL rmid_rdy_in_reset got=%0d exp=0", cStuffIf_rdy); end
        step();
        total++; if (aStuffIf_ack !== 1'b0) begin bad++; $display("FAIL rmid_ack got=%0d exp=0", aStuffIf_ack); end
        total++; if (aStuffIf_rdata !== 1'b0) begin bad++; $display("FAIL rmid_rdata got=%0d exp=0", aStuffIf_rdata); end
        total++; if (startDone_ack !== 1'b0) begin bad++; $display("FAIL rmid_sdack got=%0d exp=0", startDone_ack); end
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL rmid_outvld got=%0d exp=0", out_vld); end
        total++; if (out_data !== 5'h00) begin bad++; $display("FAIL rmid_outdata got=%0h exp=0", out_data); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", count); end
        rst_n = 1'b0;
        #1;
        total++; if (cStuffIf_rdy !== 1'b1) begin bad++; $display("FAIL rmid_release_rdy got=%0d exp=1", cStuffIf_rdy); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (aStuffIf_ack !== 1'b0) begin bad++; $display("FAIL rmid_no_ack cyc=%0d got=%0d exp=0", i, aStuffIf_ack); end
        end
        cStuffIf_vld = 1'b1; cStuffIf_data = 5'h09;
        step();
        cStuffIf_vld = 1'b0;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL rmid_push_count got=%0d exp=1", count); end
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL rmid_started_cleared got=%0d exp=0", out_vld); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_start_drain();
        test_command();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
